uart_tx_fifo_ctrl: RTL and testbench

//  Transmit holding/FIFO controller that feeds uart_tx_top. Buffers CPU THR writes and presents the head byte on dout.

---
 rtl/uart_tx_fifo_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo_ctrl
//  Brief    : Transmit holding register / FIFO controller for the UART
//             transmitter. Buffers THR writes, presents the head byte, and
//             produces LSR THRE/TEMT status plus the THRE interrupt source.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_en,
  input  logic          tx_fifo_rst,
  input  logic          wr,
  input  logic [7:0]    wdata,
  input  logic          pop,
  input  logic          sreg_empty,
  input  logic          ier_etbei,
  input  logic          iir_rd,
  output logic [7:0]    dout,
  output logic          thre,
  output logic          temt,
  output logic          full,
  output logic [AW:0]   level,
  output logic          wr_drop,
  output logic          thri
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } thri_state_t;

  // Storage and registered state
  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0] level_q, level_d;
  logic        fifo_en_q;
  logic        pop_q;
  logic        etbei_q;
  logic        thre_q, thre_d;
  logic        temt_q, temt_d;
  logic        full_q, full_d;
  logic        wr_drop_q, wr_drop_d;
  logic [7:0]  dout_q, dout_d;
  thri_state_t state_q, state_d;

  // Event decode
  logic        clear;
  logic [AW:0] cap;
  logic        full_now;
  logic        retire;
  logic        wr_acc;
  logic        thri_set;

  // Classify this cycle's events: clear, retire, accepted write, dropped write
  always_comb begin
    clear    = tx_fifo_rst | (fifo_en ^ fifo_en_q);
    cap      = fifo_en ? C_DEPTH : C_ONE;
    full_now = (level_q == cap);
    // Retire only on the falling edge of pop, once the transmitter is done with the byte
    retire   = pop_q & ~pop & (level_q != '0) & ~clear;
    // A retire in the same cycle frees a slot, so a write while full still lands
    wr_acc   = wr & ~clear & (~full_now | retire);
    wr_drop_d = wr & ~clear & full_now & ~retire;
  end

  // Next pointers, level and registered status outputs
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    if (clear) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
    end else begin
      if (wr_acc) wp_d = wp_q + 1'b1;
      if (retire) rp_d = rp_q + 1'b1;
      case ({wr_acc, retire})
        2'b10:   level_d = level_q + C_ONE;
        2'b01:   level_d = level_q - C_ONE;
        default: level_d = level_q;
      endcase
    end

    full_d = (level_d == cap);
    thre_d = (level_d == '0);

    // Head byte after this edge; a write landing in the head slot bypasses memory
    if (level_d == '0) begin
      dout_d = 8'h00;
    end else if (wr_acc && (rp_d == wp_q)) begin
      dout_d = wdata;
    end else begin
      dout_d = mem_q[rp_d];
    end

    // Transmitter-empty: an accepted write always wins over the set condition
    temt_d = temt_q;
    if (wr_acc) begin
      temt_d = 1'b0;
    end else if ((level_q == '0) && sreg_empty && !pop) begin
      temt_d = 1'b1;
    end
  end

  // THRE interrupt next state: accepted write or disable clears first, then set, then IIR read
  always_comb begin
    state_d  = state_q;
    thri_set = ier_etbei & ((thre_d & ~thre_q) | (~etbei_q & thre_q));
    if (wr_acc || !ier_etbei) begin
      state_d = S_IDLE;
    end else if (thri_set) begin
      state_d = S_PEND;
    end else if (iir_rd) begin
      state_d = S_IDLE;
    end
  end

  // Control and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      level_q   <= '0;
      fifo_en_q <= 1'b0;
      pop_q     <= 1'b0;
      etbei_q   <= 1'b0;
      thre_q    <= 1'b1;
      temt_q    <= 1'b1;
      full_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      dout_q    <= 8'h00;
      state_q   <= S_IDLE;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      level_q   <= level_d;
      fifo_en_q <= fifo_en;
      pop_q     <= pop;
      etbei_q   <= ier_etbei;
      thre_q    <= thre_d;
      temt_q    <= temt_d;
      full_q    <= full_d;
      wr_drop_q <= wr_drop_d;
      dout_q    <= dout_d;
      state_q   <= state_d;
    end
  end

  // FIFO storage; reset so no stale entry survives a reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_acc) begin
      mem_q[wp_q] <= wdata;
    end
  end

  assign dout    = dout_q;
  assign thre    = thre_q;
  assign temt    = temt_q;
  assign full    = full_q;
  assign level   = level_q;
  assign wr_drop = wr_drop_q;
  assign thri    = (state_q == S_PEND);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo_ctrl
//  Brief    : Self-checking bench for uart_tx_fifo_ctrl with a queue-based
//             reference model, directed scenarios and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_en = 1'b0;
  logic       tx_fifo_rst = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       pop = 1'b0;
  logic       sreg_empty = 1'b1;
  logic       ier_etbei = 1'b0;
  logic       iir_rd = 1'b0;
  logic [7:0] dout;
  logic       thre, temt, full, wr_drop, thri;
  logic [4:0] level;

  int n_checks = 0;
  int n_err    = 0;

  uart_tx_fifo_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .fifo_en(fifo_en), .tx_fifo_rst(tx_fifo_rst),
    .wr(wr), .wdata(wdata), .pop(pop), .sreg_empty(sreg_empty),
    .ier_etbei(ier_etbei), .iir_rd(iir_rd), .dout(dout), .thre(thre),
    .temt(temt), .full(full), .level(level), .wr_drop(wr_drop), .thri(thri)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q[$];
  bit m_en_prev = 0, m_pop_prev = 0, m_etb_prev = 0;
  bit m_thre = 1, m_temt = 1, m_full = 0, m_drop = 0, m_thri = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_en_prev = 0; m_pop_prev = 0; m_etb_prev = 0;
      m_thre = 1; m_temt = 1; m_full = 0; m_drop = 0; m_thri = 0;
    end else begin
      bit clr, fall, acc, full_now, new_thre, set;
      int cap, old_size;
      clr      = tx_fifo_rst || (fifo_en != m_en_prev);
      cap      = fifo_en ? 16 : 1;
      old_size = q.size();
      full_now = (old_size == cap);
      fall     = m_pop_prev && !pop && old_size != 0 && !clr;
      acc      = wr && !clr && (!full_now || fall);
      m_drop   = wr && !clr && full_now && !fall;
      if (clr) q.delete();
      else begin
        if (fall) void'(q.pop_front());
        if (acc) q.push_back(wdata);
      end
      new_thre = (q.size() == 0);
      m_full   = (q.size() == cap);
      if (acc) m_temt = 0;
      else if (old_size == 0 && sreg_empty && !pop) m_temt = 1;
      set = ier_etbei && ((new_thre && !m_thre) || (!m_etb_prev && m_thre));
      if (acc || !ier_etbei) m_thri = 0;
      else if (set) m_thri = 1;
      else if (iir_rd) m_thri = 0;
      m_thre     = new_thre;
      m_en_prev  = fifo_en;
      m_pop_prev = pop;
      m_etb_prev = ier_etbei;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("dout",    {24'd0, dout},   {24'd0, (q.size() != 0) ? q[0] : 8'h00});
      chk("level",   {27'd0, level},  q.size());
      chk("thre",    {31'd0, thre},   {31'd0, m_thre});
      chk("temt",    {31'd0, temt},   {31'd0, m_temt});
      chk("full",    {31'd0, full},   {31'd0, m_full});
      chk("wr_drop", {31'd0, wr_drop},{31'd0, m_drop});
      chk("thri",    {31'd0, thri},   {31'd0, m_thri});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
    wr = 0; tx_fifo_rst = 0; iir_rd = 0;
  endtask

  task automatic write(input logic [7:0] d);
    wr = 1; wdata = d; tick();
  endtask

  task automatic pop_cycle(input int n);
    pop = 1; repeat (n) tick();
    pop = 0; tick();
  endtask

  task automatic lit_reset(input string tag);
    chk({tag, "_thre"},  {31'd0, thre},  1);
    chk({tag, "_temt"},  {31'd0, temt},  1);
    chk({tag, "_level"}, {27'd0, level}, 0);
    chk({tag, "_thri"},  {31'd0, thri},  0);
    chk({tag, "_dout"},  {24'd0, dout},  0);
    chk({tag, "_full"},  {31'd0, full},  0);
  endtask

  initial begin
    int pop_left;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    tick(); tick();
    lit_reset("rst");

    // FIFO mode, three bytes, one retire
    fifo_en = 1; tick(); tick();
    write(8'h41);
    chk("t2_thre_after_wr", {31'd0, thre}, 0);
    write(8'h42); write(8'h43);
    chk("t2_level3", {27'd0, level}, 3);
    sreg_empty = 0;
    pop = 1; tick(); tick(); tick();
    chk("t2_dout_hold", {24'd0, dout}, 8'h41);
    chk("t2_level_hold", {27'd0, level}, 3);
    pop = 0; tick();
    chk("t2_dout_next", {24'd0, dout}, 8'h42);
    chk("t2_level2", {27'd0, level}, 2);
    pop_cycle(3); pop_cycle(3);
    sreg_empty = 1; tick(); tick();

    // Fill to full, overflow, then simultaneous retire and write
    for (int i = 0; i < 16; i++) write(8'(8'h10 + i));
    chk("t3_level16", {27'd0, level}, 16);
    chk("t3_full", {31'd0, full}, 1);
    write(8'hEE);
    chk("t3_drop", {31'd0, wr_drop}, 1);
    chk("t3_level_keep", {27'd0, level}, 16);
    pop = 1; tick();
    pop = 0; wr = 1; wdata = 8'hAB; tick();
    chk("t3_level_same", {27'd0, level}, 16);
    chk("t3_no_drop", {31'd0, wr_drop}, 0);
    chk("t3_dout", {24'd0, dout}, 8'h11);
    for (int i = 0; i < 16; i++) pop_cycle(2);
    tick();

    // 16450 mode
    fifo_en = 0; tick(); sreg_empty = 0;
    write(8'h55); write(8'h66);
    chk("t4_drop", {31'd0, wr_drop}, 1);
    chk("t4_temt0", {31'd0, temt}, 0);
    pop_cycle(2);
    chk("t4_thre", {31'd0, thre}, 1);
    chk("t4_temt_wait", {31'd0, temt}, 0);
    sreg_empty = 1; tick(); tick();
    chk("t4_temt1", {31'd0, temt}, 1);

    // THRE interrupt
    fifo_en = 1; tick(); tick();
    write(8'h77);
    ier_etbei = 1; tick();
    chk("t5_thri0", {31'd0, thri}, 0);
    pop_cycle(2);
    chk("t5_thri_set", {31'd0, thri}, 1);
    iir_rd = 1; tick();
    chk("t5_thri_rd", {31'd0, thri}, 0);
    ier_etbei = 0; tick(); ier_etbei = 1; tick();
    chk("t5_thri_en", {31'd0, thri}, 1);
    write(8'h88);
    chk("t5_thri_wr", {31'd0, thri}, 0);
    pop_cycle(2); tick();

    // Clear during a frame, fifo_en toggle, async reset mid-frame
    for (int i = 0; i < 4; i++) write(8'(8'hC0 + i));
    pop = 1; tick();
    tx_fifo_rst = 1; tick();
    chk("t6_clr_level", {27'd0, level}, 0);
    chk("t6_clr_thre", {31'd0, thre}, 1);
    pop = 0; tick();
    chk("t6_fall_ignored", {27'd0, level}, 0);
    write(8'h01); write(8'h02);
    fifo_en = 0; tick();
    chk("t6_toggle_clr", {27'd0, level}, 0);
    fifo_en = 1; tick();
    write(8'h03); write(8'h04); write(8'h05);
    pop = 1; tick();
    rst = 1; #1;
    lit_reset("arst");
    tick(); tick();
    pop = 0; rst = 0; tick(); tick();

    // Randomized traffic
    pop_left = 0;
    for (int c = 0; c < 4000; c++) begin
      wr     = ($urandom_range(0, 99) < 45);
      wdata  = 8'($urandom);
      iir_rd = ($urandom_range(0, 99) < 8);
      tx_fifo_rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 299) == 0) fifo_en = ~fifo_en;
      if ($urandom_range(0, 29) == 0) ier_etbei = ~ier_etbei;
      sreg_empty = ($urandom_range(0, 1) == 1);
      if (pop_left > 0) begin
        pop = 1; pop_left--;
      end else if (pop && $urandom_range(0, 1) == 1) begin
        pop = 0;
      end else if (!pop && $urandom_range(0, 99) < 35) begin
        pop = 1; pop_left = $urandom_range(0, 4);
      end else begin
        pop = 0;
      end
      @(posedge clk); #1;
    end
    wr = 0; tx_fifo_rst = 0; iir_rd = 0; pop = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
